// File: rtl/memory_access_unit_if.sv
// MEM-stage bus: M-side request and control inputs, W-side results, VGA pixel port
// and dimensions register.
interface memory_access_unit_if #(
  parameter int XLEN   = 19,
  parameter int ADDR_W = 19
);
  logic              RegWriteM;
  logic              MemWriteM;
  logic              ResultSrcM;
  logic [4:0]        RDM;
  logic [ADDR_W-1:0] ALUResultM;
  logic [XLEN-1:0]   WriteDataM;
  logic [1:0]        SizeM;
  logic              LoadSignedM;
  logic              StallM;
  logic              RegWriteW;
  logic              ResultSrcW;
  logic [4:0]        RdW;
  logic [XLEN-1:0]   ALUResultW;
  logic [XLEN-1:0]   ReadDataW;
  logic              ErrW;
  logic [ADDR_W-1:0] DataAdr_VGA;
  logic [7:0]        pixel;
  logic [15:0]       dimensiones;

  modport master (
    output RegWriteM, MemWriteM, ResultSrcM, RDM, ALUResultM, WriteDataM, SizeM,
           LoadSignedM, DataAdr_VGA,
    input  StallM, RegWriteW, ResultSrcW, RdW, ALUResultW, ReadDataW, ErrW, pixel,
           dimensiones
  );

  modport slave (
    input  RegWriteM, MemWriteM, ResultSrcM, RDM, ALUResultM, WriteDataM, SizeM,
           LoadSignedM, DataAdr_VGA,
    output StallM, RegWriteW, ResultSrcW, RdW, ALUResultW, ReadDataW, ErrW, pixel,
           dimensiones
  );
endinterface

// File: rtl/memory_access_unit.sv
// MEM stage: four byte-bank RAM with little-endian sub-word access, two-cycle
// row-crossing accesses, a memory-mapped dimensions register and a VGA read port.
module memory_access_unit #(
  parameter int                XLEN      = 19,
  parameter int                ADDR_W    = 19,
  parameter int                DEPTH     = 262144,
  parameter logic [ADDR_W-1:0] DIM_ADDR  = ADDR_W'('h7FFFE),
  parameter logic [15:0]       DIM_RESET = 16'h0000
) (
  input  logic               clk,
  input  logic               reset,
  memory_access_unit_if.slave bus
);
  localparam int              ROW_W   = ADDR_W - 2;
  localparam int              ROWS    = DEPTH / 4;
  localparam int              IDX_W   = $clog2(ROWS);
  localparam logic [ROW_W:0]  ROWS_V  = (ROW_W + 1)'(ROWS);
  localparam bit              WORD_OK = (XLEN >= 32);

  typedef enum logic {IDLE, SPLIT} state_t;
  state_t state, state_n;

  logic [1:0]        off;
  logic [ROW_W-1:0]  row;
  logic [2:0]        nbytes;
  logic              is_store, is_load, active, is_dim, in_range, fault, split;
  logic [ADDR_W+1:0] end_addr;
  logic [31:0]       wext;
  logic [3:0]        we;
  logic [1:0]        lane_k [4];
  logic              lane_hi [4];
  logic [ROW_W-1:0]  row_b [4];
  logic [IDX_W-1:0]  idx [4];
  logic [7:0]        wbyte [4];
  logic [1:0]        vga_lane, vga_lane_q;
  logic [ROW_W-1:0]  vga_row;
  logic [IDX_W-1:0]  vga_idx;
  logic              vga_ok, vga_ok_q;
  logic [31:0]       rd_all, vga_all, hold_q;
  logic              load_w, split_w, sgn_w, dim_sel_w;
  logic [1:0]        off_w;
  logic [2:0]        n_w;
  logic [15:0]       dim_q, dimval_w;
  logic [1:0]        src_lane [4];
  logic [7:0]        src [4];
  logic              top;
  logic [XLEN-1:0]   ext;

  assign off      = bus.ALUResultM[1:0];
  assign row      = bus.ALUResultM[ADDR_W-1:2];
  assign is_store = bus.MemWriteM;
  assign is_load  = bus.ResultSrcM & ~bus.MemWriteM;
  assign active   = bus.MemWriteM | bus.ResultSrcM;
  assign is_dim   = (bus.ALUResultM == DIM_ADDR);
  assign wext     = 32'(bus.WriteDataM);

  always_comb begin
    case (bus.SizeM)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  end

  // The dimensions register lives outside RAM, so only its own halfword form is legal.
  assign end_addr = {2'b00, bus.ALUResultM} + (ADDR_W + 2)'(nbytes);
  assign in_range = (end_addr <= (ADDR_W + 2)'(DEPTH));
  assign fault    = active & ((bus.SizeM == 2'b11) | ((bus.SizeM == 2'b10) & ~WORD_OK) |
                              (is_dim ? (bus.SizeM != 2'b01) : ~in_range));
  assign split    = active & ~fault & ~is_dim & (({1'b0, off} + nbytes) > 3'd4);

  always_comb begin
    state_n    = state;
    bus.StallM = 1'b0;
    case (state)
      IDLE: if (split) begin
        bus.StallM = reset;
        state_n    = SPLIT;
      end
      SPLIT: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Banks below the start offset belong to the next row; they are touched only in SPLIT.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      lane_k[b]  = 2'(b) - off;
      lane_hi[b] = (2'(b) < off);
      row_b[b]   = lane_hi[b] ? row + ROW_W'(1) : row;
      idx[b]     = ({1'b0, row_b[b]} < ROWS_V) ? IDX_W'(row_b[b]) : '0;
      wbyte[b]   = wext[{lane_k[b], 3'b000} +: 8];
      we[b]      = reset & is_store & ~fault & ~is_dim & ({1'b0, lane_k[b]} < nbytes) &
                   ((state == SPLIT) ? lane_hi[b] : ~lane_hi[b]);
    end
  end

  assign vga_lane = bus.DataAdr_VGA[1:0];
  assign vga_row  = bus.DataAdr_VGA[ADDR_W-1:2];
  assign vga_ok   = ({1'b0, vga_row} < ROWS_V);
  assign vga_idx  = vga_ok ? IDX_W'(vga_row) : '0;

  for (genvar g = 0; g < 4; g++) begin : g_bank
    logic [7:0] mem [ROWS];
    logic [7:0] rd_q, vga_q;
    always_ff @(posedge clk) begin
      if (we[g]) mem[idx[g]] <= wbyte[g];
      rd_q  <= we[g] ? wbyte[g] : mem[idx[g]];
      vga_q <= mem[vga_idx];
    end
    assign rd_all[8*g +: 8]  = rd_q;
    assign vga_all[8*g +: 8] = vga_q;
  end

  // The first half of a split access produces a bubble; the held low-row bytes are
  // merged with the second read when the full result reaches W.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.RegWriteW  <= 1'b0;
      bus.ResultSrcW <= 1'b0;
      bus.RdW        <= '0;
      bus.ALUResultW <= '0;
      bus.ErrW       <= 1'b0;
      load_w         <= 1'b0;
      split_w        <= 1'b0;
      sgn_w          <= 1'b0;
      dim_sel_w      <= 1'b0;
      off_w          <= '0;
      n_w            <= 3'd1;
      dimval_w       <= '0;
      dim_q          <= DIM_RESET;
      vga_ok_q       <= 1'b0;
      vga_lane_q     <= '0;
      hold_q         <= '0;
    end else begin
      vga_ok_q   <= vga_ok;
      vga_lane_q <= vga_lane;
      if (state == SPLIT) hold_q <= rd_all;
      if (is_store & is_dim & ~fault) dim_q <= bus.WriteDataM[15:0];
      if ((state == IDLE) && split) begin
        bus.RegWriteW  <= 1'b0;
        bus.ResultSrcW <= 1'b0;
        bus.RdW        <= '0;
        bus.ALUResultW <= '0;
        bus.ErrW       <= 1'b0;
        load_w         <= 1'b0;
      end else begin
        bus.RegWriteW  <= bus.RegWriteM & ~(fault & bus.ResultSrcM);
        bus.ResultSrcW <= bus.ResultSrcM;
        bus.RdW        <= bus.RDM;
        bus.ALUResultW <= XLEN'(bus.ALUResultM);
        bus.ErrW       <= fault;
        load_w         <= is_load & ~fault;
        split_w        <= (state == SPLIT);
        sgn_w          <= bus.LoadSignedM;
        dim_sel_w      <= is_dim;
        off_w          <= off;
        n_w            <= nbytes;
        dimval_w       <= dim_q;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      src_lane[k] = off_w + 2'(k);
      src[k] = (split_w && (src_lane[k] >= off_w)) ? hold_q[{src_lane[k], 3'b000} +: 8]
                                                   : rd_all[{src_lane[k], 3'b000} +: 8];
    end
    if (dim_sel_w) begin
      src[0] = dimval_w[7:0];
      src[1] = dimval_w[15:8];
      src[2] = 8'h00;
      src[3] = 8'h00;
    end
    top = sgn_w & src[2'(n_w - 3'd1)][7];
    for (int i = 0; i < XLEN; i++)
      ext[i] = (i < 8 * int'(n_w)) ? src[(i / 8) % 4][i % 8] : top;
  end

  assign bus.ReadDataW   = load_w ? ext : '0;
  assign bus.dimensiones = dim_q;
  assign bus.pixel       = vga_ok_q ? vga_all[{vga_lane_q, 3'b000} +: 8] : 8'h00;
endmodule

// File: tb/tb_memory_access_unit.sv
// Self-checking bench for memory_access_unit: directed test-plan steps followed by
// randomized accesses against a byte-array reference model.
module tb_memory_access_unit;
  localparam int          XLEN     = 19;
  localparam int          DEPTH    = 262144;
  localparam logic [18:0] DIM_ADDR = 19'h7FFFE;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  byte unsigned ram_model [DEPTH];
  logic [15:0]  dim_model;

  memory_access_unit_if #(.XLEN(19), .ADDR_W(19)) bus ();

  memory_access_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic setIdle();
    bus.RegWriteM   = 1'b0;
    bus.MemWriteM   = 1'b0;
    bus.ResultSrcM  = 1'b0;
    bus.RDM         = '0;
    bus.ALUResultM  = '0;
    bus.WriteDataM  = '0;
    bus.SizeM       = 2'b00;
    bus.LoadSignedM = 1'b0;
  endtask

  // One access from the M stage to its W slot, expectations computed from the byte model.
  task automatic applyStimulus(input logic we, input logic rs, input logic rw,
                               input logic [1:0] size, input logic [18:0] addr,
                               input logic [18:0] wdata, input logic sgn,
                               input logic [4:0] rd);
    int          n;
    bit          act, dim, flt, spl, exp_rw;
    logic [63:0] v;
    logic [18:0] exp_data;
    n   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    act = we | rs;
    dim = (addr == DIM_ADDR);
    flt = act && ((size == 2'b11) || (size == 2'b10 && XLEN < 32) ||
                  (dim ? (size != 2'b01) : (int'(addr) + n > DEPTH)));
    spl = act && !flt && !dim && ((int'(addr) % 4) + n > 4);
    v = 64'd0;
    if (rs && !we && !flt) begin
      if (dim) v = 64'(dim_model);
      else for (int k = 0; k < n; k++) v = v | (64'(ram_model[int'(addr) + k]) << (8 * k));
      if (sgn && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    end
    exp_data = v[18:0];
    exp_rw   = rw && !(flt && rs);

    bus.MemWriteM = we; bus.ResultSrcM = rs; bus.RegWriteM = rw; bus.SizeM = size;
    bus.ALUResultM = addr; bus.WriteDataM = wdata; bus.LoadSignedM = sgn; bus.RDM = rd;
    #1;
    checkOutput("stall", 32'(bus.StallM), 32'(spl));
    @(posedge clk); #1;
    if (spl) begin
      checkOutput("bubble_regwrite", 32'(bus.RegWriteW), 32'd0);
      checkOutput("bubble_err", 32'(bus.ErrW), 32'd0);
      checkOutput("split_stall", 32'(bus.StallM), 32'd0);
      @(posedge clk); #1;
    end
    checkOutput("regwrite_w", 32'(bus.RegWriteW), 32'(exp_rw));
    checkOutput("resultsrc_w", 32'(bus.ResultSrcW), 32'(rs));
    checkOutput("rd_w", 32'(bus.RdW), 32'(rd));
    checkOutput("aluresult_w", 32'(bus.ALUResultW), 32'(addr));
    checkOutput("readdata_w", 32'(bus.ReadDataW), 32'(exp_data));
    checkOutput("err_w", 32'(bus.ErrW), 32'(flt));

    if (we && !flt) begin
      if (dim) dim_model = wdata[15:0];
      else for (int k = 0; k < n; k++) ram_model[int'(addr) + k] = 8'(wdata >> (8 * k));
    end
    checkOutput("dimensiones", 32'(bus.dimensiones), 32'(dim_model));
  endtask

  task automatic vgaCheck(input logic [18:0] addr);
    logic [7:0] expected;
    setIdle();
    bus.DataAdr_VGA = addr;
    expected = (int'(addr) < DEPTH) ? ram_model[int'(addr)] : 8'h00;
    @(posedge clk); #1;
    checkOutput("pixel", 32'(bus.pixel), 32'(expected));
  endtask

  initial begin
    logic [7:0]  old_px;
    logic [18:0] ra;
    int          op;
    tests_run    = 0;
    tests_failed = 0;
    dim_model    = 16'h0000;
    reset        = 1'b0;
    setIdle();
    bus.DataAdr_VGA = 19'h8;

    // A row-crossing store held during reset must neither stall nor write.
    bus.MemWriteM = 1'b1; bus.RegWriteM = 1'b1; bus.SizeM = 2'b01;
    bus.ALUResultM = 19'h3; bus.WriteDataM = 19'h1234;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_stall", 32'(bus.StallM), 32'd0);
    checkOutput("reset_regwrite", 32'(bus.RegWriteW), 32'd0);
    checkOutput("reset_resultsrc", 32'(bus.ResultSrcW), 32'd0);
    checkOutput("reset_rd", 32'(bus.RdW), 32'd0);
    checkOutput("reset_alu", 32'(bus.ALUResultW), 32'd0);
    checkOutput("reset_readdata", 32'(bus.ReadDataW), 32'd0);
    checkOutput("reset_err", 32'(bus.ErrW), 32'd0);
    checkOutput("reset_pixel", 32'(bus.pixel), 32'd0);
    checkOutput("reset_dim", 32'(bus.dimensiones), 32'd0);
    reset = 1'b1;
    setIdle();

    for (int a = 0; a < 64; a++)
      applyStimulus(1, 0, 0, 2'b00, 19'(a), 19'($urandom_range(0, 255)), 0, 5'd0);
    for (int a = DEPTH - 8; a < DEPTH; a++)
      applyStimulus(1, 0, 0, 2'b00, 19'(a), 19'($urandom_range(0, 255)), 0, 5'd0);

    applyStimulus(1, 0, 0, 2'b00, 19'h8, 19'h3, 0, 5'd0);
    applyStimulus(0, 1, 1, 2'b00, 19'h8, 19'h0, 0, 5'd3);
    applyStimulus(1, 0, 0, 2'b01, 19'h6, 19'hEEFF, 0, 5'd0);
    applyStimulus(1, 0, 0, 2'b00, 19'h7, 19'hAA, 0, 5'd0);
    applyStimulus(0, 1, 1, 2'b01, 19'h6, 19'h0, 0, 5'd4);
    applyStimulus(0, 1, 1, 2'b00, 19'h7, 19'h0, 1, 5'd5);
    applyStimulus(1, 0, 0, 2'b01, 19'h3, 19'h1234, 0, 5'd0);
    applyStimulus(0, 1, 1, 2'b01, 19'h3, 19'h0, 0, 5'd6);
    applyStimulus(0, 1, 1, 2'b00, 19'h3, 19'h0, 0, 5'd7);
    applyStimulus(0, 1, 1, 2'b00, 19'h4, 19'h0, 0, 5'd8);
    applyStimulus(1, 0, 0, 2'b01, DIM_ADDR, 19'h5040, 0, 5'd0);
    applyStimulus(1, 0, 0, 2'b00, DIM_ADDR, 19'h77, 0, 5'd0);
    applyStimulus(0, 1, 1, 2'b01, DIM_ADDR, 19'h0, 1, 5'd9);
    applyStimulus(0, 1, 1, 2'b11, 19'h10, 19'h0, 0, 5'd10);
    applyStimulus(1, 0, 0, 2'b10, 19'h0, 19'h7FFFF, 0, 5'd0);
    applyStimulus(0, 1, 1, 2'b00, 19'h0, 19'h0, 0, 5'd11);
    applyStimulus(0, 1, 1, 2'b01, 19'(DEPTH - 1), 19'h0, 0, 5'd12);
    applyStimulus(0, 0, 1, 2'b01, 19'h3, 19'h0, 0, 5'd13);

    vgaCheck(19'h8);
    vgaCheck(19'(DEPTH));
    vgaCheck(19'(DEPTH - 1));

    bus.DataAdr_VGA = 19'h20;
    old_px = ram_model[32];
    applyStimulus(1, 0, 0, 2'b00, 19'h20, 19'(8'(~old_px)), 0, 5'd0);
    checkOutput("pixel_collision_old", 32'(bus.pixel), 32'(old_px));
    vgaCheck(19'h20);

    // Reset arrives after the first half of a split store has been committed.
    bus.MemWriteM = 1'b1; bus.ResultSrcM = 1'b0; bus.RegWriteM = 1'b1; bus.SizeM = 2'b01;
    bus.ALUResultM = 19'h3; bus.WriteDataM = 19'hBEEF; bus.RDM = 5'd14;
    #1;
    checkOutput("rst_split_stall", 32'(bus.StallM), 32'd1);
    @(posedge clk); #1;
    ram_model[3] = 8'hEF;
    reset = 1'b0;
    #1;
    checkOutput("rst_split_stall_low", 32'(bus.StallM), 32'd0);
    @(posedge clk); #1;
    dim_model = 16'h0000;
    checkOutput("rst_split_regwrite", 32'(bus.RegWriteW), 32'd0);
    checkOutput("rst_split_alu", 32'(bus.ALUResultW), 32'd0);
    checkOutput("rst_split_rd", 32'(bus.RdW), 32'd0);
    checkOutput("rst_split_err", 32'(bus.ErrW), 32'd0);
    checkOutput("rst_split_pixel", 32'(bus.pixel), 32'd0);
    checkOutput("rst_split_dim", 32'(bus.dimensiones), 32'd0);
    reset = 1'b1;
    setIdle();
    applyStimulus(0, 1, 1, 2'b01, 19'h3, 19'h0, 0, 5'd15);

    for (int it = 0; it < 200; it++) begin
      op = $urandom_range(0, 19);
      if (op < 14)      ra = 19'($urandom_range(0, 60));
      else if (op < 17) ra = 19'(DEPTH - 6 + $urandom_range(0, 5));
      else              ra = DIM_ADDR;
      op = $urandom_range(0, 2);
      applyStimulus(op == 1, op == 2, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    ra, 19'($urandom & 32'h7FFFF), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 31)));
    end

    for (int it = 0; it < 8; it++) vgaCheck(19'($urandom_range(0, 63)));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
